// File: rtl/pcileech_tlps128_tx_pktbuf.sv
`default_nettype none
// ============================================================================
//  Module   : pcileech_tlps128_tx_pktbuf
//  Purpose  : 128-bit TLP transmit packet buffer sitting between the TLP sink
//             mux and the PCIe core TX port. Whole packets are buffered before
//             forwarding (store-and-forward). A packet too large to fit is
//             streamed through in cut-through mode once the buffer fills.
//  Ports    : clk_pcie                - sole clock, rising edge
//             rst                     - asynchronous active-high reset
//             in_t*                   - input beat stream (tdata/tkeepdw/tlast/
//                                       tuser/tvalid/tready)
//             out_t*                  - output beat stream to PCIe core TX
//             out_has_data            - packet available or in flight
//             stat_pkt_count          - TLPs delivered
//             stat_cut_count          - cut-through entries (saturating)
//  Options  : define PCILEECH_TXBUF_STATS_EN to enable the statistics
//             counters; otherwise both stat outputs are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module pcileech_tlps128_tx_pktbuf #(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic         clk_pcie,
    input  logic         rst,
    input  logic [127:0] in_tdata,
    input  logic [3:0]   in_tkeepdw,
    input  logic         in_tlast,
    input  logic [8:0]   in_tuser,
    input  logic         in_tvalid,
    output logic         in_tready,
    output logic [127:0] out_tdata,
    output logic [3:0]   out_tkeepdw,
    output logic         out_tlast,
    output logic [8:0]   out_tuser,
    output logic         out_tvalid,
    input  logic         out_tready,
    output logic         out_has_data,
    output logic [31:0]  stat_pkt_count,
    output logic [15:0]  stat_cut_count
);

    localparam int                  c_DEPTH_INT = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH     = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] c_OCC_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_CUT  = 2'd2
    } state_t;

    // Stored word layout: {tuser[141:133], tlast[132], tkeepdw[131:128], tdata[127:0]}
    logic [141:0]          r_mem [0:c_DEPTH_INT-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_occ;
    logic [DEPTH_LOG2:0]   r_pkt_cnt;
    logic                  r_in_tready;
    logic                  r_out_tvalid;
    logic [127:0]          r_out_tdata;
    logic [3:0]            r_out_tkeepdw;
    logic                  r_out_tlast;
    logic [8:0]            r_out_tuser;
    state_t                r_state;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_pop_last;
    logic                  w_cut_enter;
    logic [141:0]          w_rd_word;
    logic [DEPTH_LOG2:0]   w_occ_next;

    assign w_push     = in_tvalid && r_in_tready;
    assign w_rd_word  = r_mem[r_rd_ptr];
    assign w_pop_last = w_rd_word[132];

    // A beat moves into the output register when that register is free (or
    // being drained this cycle) and either a complete packet is buffered or we
    // are already streaming a packet out.
    assign w_pop = (!r_out_tvalid || out_tready) && (r_occ != '0) &&
                   ((r_state != ST_IDLE) || (r_pkt_cnt != '0));

    // Buffer full without any complete packet: the packet cannot fit, so it
    // must be streamed through instead of deadlocking.
    assign w_cut_enter = (r_state == ST_IDLE) && (r_pkt_cnt == '0) && (r_occ == c_DEPTH);

    always_comb begin
        w_occ_next = r_occ;
        if (w_push && !w_pop) begin
            w_occ_next = r_occ + c_OCC_ONE;
        end else if (!w_push && w_pop) begin
            w_occ_next = r_occ - c_OCC_ONE;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_pcie) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_tuser, in_tlast, in_tkeepdw, in_tdata};
        end
    end

    always_ff @(posedge clk_pcie or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_occ         <= '0;
            r_pkt_cnt     <= '0;
            r_in_tready   <= 1'b0;
            r_out_tvalid  <= 1'b0;
            r_out_tdata   <= '0;
            r_out_tkeepdw <= '0;
            r_out_tlast   <= 1'b0;
            r_out_tuser   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_occ       <= w_occ_next;
            // Ready is registered from the next occupancy so it never depends
            // combinationally on the output side.
            r_in_tready <= (w_occ_next != c_DEPTH);

            if ((w_push && in_tlast) && !(w_pop && w_pop_last)) begin
                r_pkt_cnt <= r_pkt_cnt + c_OCC_ONE;
            end else if (!(w_push && in_tlast) && (w_pop && w_pop_last)) begin
                r_pkt_cnt <= r_pkt_cnt - c_OCC_ONE;
            end

            if (w_pop) begin
                r_out_tvalid <= 1'b1;
                {r_out_tuser, r_out_tlast, r_out_tkeepdw, r_out_tdata} <= w_rd_word;
            end else if (out_tready) begin
                r_out_tvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_pcie or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pkt_cnt != '0) begin
                        // A single-beat packet popped straight from idle is
                        // already finished; stay idle.
                        if (!(w_pop && w_pop_last)) begin
                            r_state <= ST_FWD;
                        end
                    end else if (w_cut_enter) begin
                        r_state <= ST_CUT;
                    end
                end
                ST_FWD, ST_CUT: begin
                    if (w_pop && w_pop_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef PCILEECH_TXBUF_STATS_EN
    logic [31:0] r_stat_pkt;
    logic [15:0] r_stat_cut;

    always_ff @(posedge clk_pcie or posedge rst) begin
        if (rst) begin
            r_stat_pkt <= '0;
            r_stat_cut <= '0;
        end else begin
            if (r_out_tvalid && out_tready && r_out_tlast) begin
                r_stat_pkt <= r_stat_pkt + 32'd1;
            end
            if (w_cut_enter && (r_stat_cut != 16'hFFFF)) begin
                r_stat_cut <= r_stat_cut + 16'd1;
            end
        end
    end

    assign stat_pkt_count = r_stat_pkt;
    assign stat_cut_count = r_stat_cut;
`else
    assign stat_pkt_count = 32'd0;
    assign stat_cut_count = 16'd0;
`endif

    assign in_tready    = r_in_tready;
    assign out_tvalid   = r_out_tvalid;
    assign out_tdata    = r_out_tdata;
    assign out_tkeepdw  = r_out_tkeepdw;
    assign out_tlast    = r_out_tlast;
    assign out_tuser    = r_out_tuser;
    assign out_has_data = r_out_tvalid || (r_pkt_cnt != '0) || (r_state == ST_CUT);

endmodule
`default_nettype wire

// File: tb/tb_pcileech_tlps128_tx_pktbuf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pcileech_tlps128_tx_pktbuf
//  Purpose  : Self-checking bench for the TLP TX packet buffer (16-beat build).
//             Expected beats come from an in-order queue of everything the
//             input side handed over; the buffer must reproduce that queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pcileech_tlps128_tx_pktbuf;

    localparam int DL2 = 4;

    logic         clk_pcie = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] in_tdata = '0;
    logic [3:0]   in_tkeepdw = '0;
    logic         in_tlast = 1'b0;
    logic [8:0]   in_tuser = '0;
    logic         in_tvalid = 1'b0;
    logic         in_tready;
    logic [127:0] out_tdata;
    logic [3:0]   out_tkeepdw;
    logic         out_tlast;
    logic [8:0]   out_tuser;
    logic         out_tvalid;
    logic         out_tready = 1'b0;
    logic         out_has_data;
    logic [31:0]  stat_pkt_count;
    logic [15:0]  stat_cut_count;

    pcileech_tlps128_tx_pktbuf #(.DEPTH_LOG2(DL2)) dut (
        .clk_pcie      (clk_pcie),
        .rst           (rst),
        .in_tdata      (in_tdata),
        .in_tkeepdw    (in_tkeepdw),
        .in_tlast      (in_tlast),
        .in_tuser      (in_tuser),
        .in_tvalid     (in_tvalid),
        .in_tready     (in_tready),
        .out_tdata     (out_tdata),
        .out_tkeepdw   (out_tkeepdw),
        .out_tlast     (out_tlast),
        .out_tuser     (out_tuser),
        .out_tvalid    (out_tvalid),
        .out_tready    (out_tready),
        .out_has_data  (out_has_data),
        .stat_pkt_count(stat_pkt_count),
        .stat_cut_count(stat_cut_count)
    );

    always #5 clk_pcie = ~clk_pcie;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [141:0] exp_q[$];
    int cyc = 0;
    int acc_cnt = 0;
    int out_beats = 0;
    int pkts_out = 0;
    int exp_cut = 0;
    int first_out_cyc = -1;
    int acc_at_first_out = 0;
    int last_in_cyc = 0;

    // out_tready control: 0 fixed level, 1 random, 2 toggle every cycle
    int   rdy_mode = 0;
    logic rdy_fixed = 1'b0;

    logic [3:0] thermo [4] = '{4'h1, 4'h3, 4'h7, 4'hF};

    task automatic checkw(input string name, input logic [141:0] act, input logic [141:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checkw(name, 142'(act), 142'(req));
    endtask

    task automatic tick();
        @(posedge clk_pcie);
        #1;
    endtask

    task automatic set_beat(input logic first, input logic last);
        in_tdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_tkeepdw = thermo[$urandom_range(0, 3)];
        in_tuser   = {8'($urandom_range(0, 255)), first};
        in_tlast   = last;
        in_tvalid  = 1'b1;
    endtask

    // Offer one beat and hold it until the buffer takes it.
    task automatic send_beat(input logic first, input logic last, output int waited);
        set_beat(first, last);
        waited = 0;
        while (!in_tready && waited < 300) begin
            tick();
            waited++;
        end
        if (waited >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_tready_timeout: actual=0 required=1");
        end
        tick();
        in_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int n, input int gap_pct, output int waits);
        int w;
        waits = 0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < gap_pct) tick();
            send_beat(i == 0, i == n - 1, w);
            waits += w;
        end
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while ((exp_q.size() != 0 || out_tvalid) && guard < 500) begin
            tick();
            guard++;
        end
        checkw({name, "_drain_left"}, 142'(exp_q.size()), 142'(0));
        check1({name, "_has_data_idle"}, out_has_data, 1'b0);
    endtask

    task automatic check_stats(input string name);
`ifdef PCILEECH_TXBUF_STATS_EN
        checkw({name, "_stat_pkt"}, 142'(stat_pkt_count), 142'(pkts_out));
        checkw({name, "_stat_cut"}, 142'(stat_cut_count), 142'(exp_cut));
`else
        checkw({name, "_stat_pkt"}, 142'(stat_pkt_count), 142'(0));
        checkw({name, "_stat_cut"}, 142'(stat_cut_count), 142'(0));
`endif
    endtask

    // out_tready driver: runs after the main sequence's #1 updates.
    initial begin
        forever begin
            @(posedge clk_pcie);
            #2;
            case (rdy_mode)
                0:       out_tready = rdy_fixed;
                1:       out_tready = ($urandom_range(0, 3) != 0);
                default: out_tready = !out_tready;
            endcase
        end
    end

    // Monitor / scoreboard, sampled mid-cycle.
    initial begin
        logic         stalled;
        logic [141:0] held;
        logic [141:0] word;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk_pcie);
            cyc++;
            word = {out_tuser, out_tlast, out_tkeepdw, out_tdata};
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) checkw("stall_hold", {out_tvalid, word}, {1'b1, held});
                if (out_tvalid && first_out_cyc < 0) begin
                    first_out_cyc = cyc;
                    acc_at_first_out = acc_cnt;
                end
                if (in_tvalid && in_tready) begin
                    exp_q.push_back({in_tuser, in_tlast, in_tkeepdw, in_tdata});
                    acc_cnt++;
                    if (in_tlast) last_in_cyc = cyc;
                end
                if (out_tvalid && out_tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_beat: actual=%0h required=none", word);
                    end else begin
                        checkw("beat_data", word, exp_q.pop_front());
                    end
                    out_beats++;
                    if (out_tlast) pkts_out++;
                end
                stalled = out_tvalid && !out_tready;
                held = word;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic v;      // in_tvalid
        logic l;      // in_tlast
        logic r;      // out_tready
        logic e_tr;   // expected in_tready
        logic e_tv;   // expected out_tvalid
        logic e_hd;   // expected out_has_data
    } vec_t;

    initial begin
        vec_t tbl[8];
        int   w, w2, base, base_out;
        logic released;

        // One 3-beat TLP into an empty buffer, sink always ready.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        // ---- reset state ----
        repeat (3) @(posedge clk_pcie);
        #1;
        check1("rst_out_tvalid", out_tvalid, 1'b0);
        check1("rst_has_data", out_has_data, 1'b0);
        check1("rst_in_tready", in_tready, 1'b0);
        checkw("rst_out_word", {out_tuser, out_tlast, out_tkeepdw, out_tdata}, 142'(0));
        check_stats("rst");
        rst = 1'b0;
        #1;
        check1("rst_release_in_tready_low", in_tready, 1'b0);
        tick();
        check1("rst_release_in_tready_high", in_tready, 1'b1);

        // ---- 3-beat TLP, cycle-accurate table ----
        first_out_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].v) set_beat(i == 0, tbl[i].l);
            else in_tvalid = 1'b0;
            rdy_fixed = tbl[i].r;
            @(negedge clk_pcie);
            check1("tbl_in_tready", in_tready, tbl[i].e_tr);
            check1("tbl_out_tvalid", out_tvalid, tbl[i].e_tv);
            check1("tbl_has_data", out_has_data, tbl[i].e_hd);
            @(posedge clk_pcie);
            #1;
        end
        in_tvalid = 1'b0;
        checkw("latency_last_in_to_first_out", 142'(first_out_cyc - last_in_cyc), 142'(2));
        checkw("tbl_beats", 142'(out_beats), 142'(3));

        // ---- 2-beat + 4-beat TLPs behind a 10-cycle stall ----
        rdy_fixed = 1'b0;
        base_out = out_beats;
        send_pkt(2, 0, w);
        send_pkt(4, 0, w2);
        checkw("stall_in_tready_waits", 142'(w + w2), 142'(0));
        repeat (4) tick();
        rdy_fixed = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_pcie);
            check1("contig_transfer", out_tvalid && out_tready, 1'b1);
            @(posedge clk_pcie);
            #1;
        end
        @(negedge clk_pcie);
        check1("contig_end_tvalid", out_tvalid, 1'b0);
        @(posedge clk_pcie);
        #1;
        checkw("contig_beats", 142'(out_beats - base_out), 142'(6));

        // ---- five 4-beat TLPs into a stalled 16-deep buffer ----
        drain("pre_full");
        rdy_fixed = 1'b0;
        base = acc_cnt;
        base_out = out_beats;
        released = 1'b0;
        for (int p = 0; p < 5; p++) begin
            for (int b = 0; b < 4; b++) begin
                if (!released && !in_tready) begin
                    // 16 RAM entries plus the one beat parked in the output register
                    checkw("full_accept_count", 142'(acc_cnt - base), 142'(17));
                    rdy_fixed = 1'b1;
                    released = 1'b1;
                end
                send_beat(b == 0, b == 3, w);
            end
        end
        check1("full_reached", released, 1'b1);
        drain("full");
        checkw("full_beats", 142'(out_beats - base_out), 142'(20));

        // ---- 24-beat TLP forces cut-through ----
        rdy_fixed = 1'b1;
        first_out_cyc = -1;
        base = acc_cnt;
        base_out = out_beats;
        send_pkt(24, 0, w);
        exp_cut++;
        checkw("cut_first_out_at_occupancy", 142'(acc_at_first_out - base), 142'(16));
        drain("cut");
        checkw("cut_beats", 142'(out_beats - base_out), 142'(24));
        check_stats("cut");

        // ---- 8-beat TLP with out_tready toggling ----
        rdy_mode = 2;
        base_out = out_beats;
        send_pkt(8, 0, w);
        drain("toggle");
        checkw("toggle_beats", 142'(out_beats - base_out), 142'(8));

        // ---- randomized traffic ----
        rdy_mode = 1;
        base_out = out_beats;
        base = acc_cnt;
        for (int p = 0; p < 30; p++) begin
            send_pkt($urandom_range(1, 8), 30, w);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) tick();
        end
        drain("rand");
        checkw("rand_beats", 142'(out_beats - base_out), 142'(acc_cnt - base));
        rdy_mode = 0;
        rdy_fixed = 1'b1;
        tick();
        check_stats("rand");

        // ---- reset mid-packet ----
        send_beat(1'b1, 1'b0, w);
        send_beat(1'b0, 1'b0, w);
        rst = 1'b1;
        exp_q.delete();
        pkts_out = 0;
        exp_cut = 0;
        #1;
        check1("midrst_out_tvalid", out_tvalid, 1'b0);
        check1("midrst_has_data", out_has_data, 1'b0);
        check1("midrst_in_tready", in_tready, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check1("midrst_in_tready_back", in_tready, 1'b1);
        base_out = out_beats;
        send_pkt(1, 0, w);
        drain("midrst");
        checkw("midrst_beats", 142'(out_beats - base_out), 142'(1));
        check_stats("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
